// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - Op codes, SPARC trap types and FSM encoding for the window sequencer
package window_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_SAVE    = 3'd1;
  localparam logic [2:0] OP_RESTORE = 3'd2;
  localparam logic [2:0] OP_TRAP    = 3'd3;
  localparam logic [2:0] OP_RETT    = 3'd4;
  localparam logic [2:0] OP_WRCWP   = 3'd5;
  localparam logic [2:0] OP_WRWIM   = 3'd6;

  localparam logic [7:0] TT_ILLEGAL = 8'h02;
  localparam logic [7:0] TT_PRIV    = 8'h03;
  localparam logic [7:0] TT_WOVF    = 8'h05;
  localparam logic [7:0] TT_WUNF    = 8'h06;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_RESP  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

endpackage

// File: rtl/window_ctrl_cwp_step.sv
// rtl/window_ctrl_cwp_step.sv - Neighbouring window pointers of CWP, modulo NWINDOWS
module cwp_step #(
  parameter int NWINDOWS = 3
) (
  input  logic [4:0] cwp,
  output logic [4:0] inc,
  output logic [4:0] dec
);

  localparam logic [4:0] LAST = 5'(NWINDOWS - 1);

  assign inc = (cwp == LAST) ? 5'd0 : cwp + 5'd1;
  assign dec = (cwp == 5'd0) ? LAST : cwp - 5'd1;

endmodule

// File: rtl/window_ctrl.sv
// rtl/window_ctrl.sv - CWP/WIM/ET/S/PS sequencer; `define WIN_STATS_EN adds overflow/underflow counters
module window_ctrl
  import window_pkg::*;
#(
  parameter int NWINDOWS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [2:0]          op_code,
  input  logic [31:0]         op_data,
  output logic                op_ready,
  output logic                done_valid,
  output logic                done_trap,
  output logic [7:0]          done_tt,
  output logic [4:0]          cwp_out,
  output logic [NWINDOWS-1:0] wim_out,
  output logic                et_out,
  output logic                s_out,
  output logic                error_mode,
  output logic [15:0]         ovf_cnt,
  output logic [15:0]         unf_cnt
);

  // Only the operand bits any op can consume are latched: tt needs 8, WRWIM needs NWINDOWS.
  localparam int DW = (NWINDOWS > 8) ? NWINDOWS : 8;
  localparam logic [4:0] NW5 = 5'(NWINDOWS);

  state_t          state;
  logic [2:0]      code_q;
  logic [DW-1:0]   data_q;
  logic            ps;
  logic [4:0]      inc, dec;
  logic            wim_inc, wim_dec;
  logic            unused_data;

  assign unused_data = ^op_data[31:DW];

  cwp_step #(.NWINDOWS(NWINDOWS)) u_step (
    .cwp (cwp_out),
    .inc (inc),
    .dec (dec)
  );

  assign wim_dec = |(wim_out & (NWINDOWS'(1) << dec));
  assign wim_inc = |(wim_out & (NWINDOWS'(1) << inc));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      code_q     <= '0;
      data_q     <= '0;
      op_ready   <= 1'b1;
      done_valid <= 1'b0;
      done_trap  <= 1'b0;
      done_tt    <= '0;
      cwp_out    <= '0;
      wim_out    <= '0;
      et_out     <= 1'b0;
      s_out      <= 1'b1;
      ps         <= 1'b0;
      error_mode <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid && op_ready) begin
            code_q   <= op_code;
            data_q   <= op_data[DW-1:0];
            op_ready <= 1'b0;
            state    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          done_valid <= 1'b1;
          done_trap  <= 1'b0;
          done_tt    <= '0;
          state      <= ST_RESP;
          case (code_q)
            OP_SAVE: begin
              if (wim_dec) begin
                done_trap <= 1'b1;
                done_tt   <= TT_WOVF;
              end else begin
                cwp_out <= dec;
              end
            end
            OP_RESTORE: begin
              if (wim_inc) begin
                done_trap <= 1'b1;
                done_tt   <= TT_WUNF;
              end else begin
                cwp_out <= inc;
              end
            end
            OP_TRAP: begin
              done_tt <= data_q[7:0];
              if (et_out) begin
                cwp_out <= dec;
                ps      <= s_out;
                s_out   <= 1'b1;
                et_out  <= 1'b0;
              end else begin
                // Trap with traps disabled: the core is dead until reset.
                error_mode <= 1'b1;
                done_trap  <= 1'b1;
                state      <= ST_ERROR;
              end
            end
            OP_RETT: begin
              if (et_out) begin
                done_trap <= 1'b1;
                done_tt   <= TT_ILLEGAL;
              end else if (!s_out) begin
                done_trap <= 1'b1;
                done_tt   <= TT_PRIV;
              end else if (wim_inc) begin
                done_trap <= 1'b1;
                done_tt   <= TT_WUNF;
              end else begin
                cwp_out <= inc;
                s_out   <= ps;
                et_out  <= 1'b1;
              end
            end
            OP_WRCWP: begin
              if (!s_out) begin
                done_trap <= 1'b1;
                done_tt   <= TT_PRIV;
              end else if (data_q[4:0] >= NW5) begin
                done_trap <= 1'b1;
                done_tt   <= TT_ILLEGAL;
              end else begin
                cwp_out <= data_q[4:0];
              end
            end
            OP_WRWIM: begin
              if (!s_out) begin
                done_trap <= 1'b1;
                done_tt   <= TT_PRIV;
              end else begin
                wim_out <= data_q[NWINDOWS-1:0];
              end
            end
            default: ;
          endcase
        end
        ST_RESP: begin
          done_valid <= 1'b0;
          done_trap  <= 1'b0;
          done_tt    <= '0;
          op_ready   <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_ERROR: begin
          done_valid <= 1'b0;
          done_trap  <= 1'b0;
          done_tt    <= '0;
          op_ready   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WIN_STATS_EN
  logic ovf_hit, unf_hit;

  assign ovf_hit = (state == ST_EVAL) && (code_q == OP_SAVE) && wim_dec;
  assign unf_hit = (state == ST_EVAL) && wim_inc &&
                   ((code_q == OP_RESTORE) || ((code_q == OP_RETT) && !et_out && s_out));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (ovf_hit && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
      if (unf_hit && (unf_cnt != 16'hFFFF)) unf_cnt <= unf_cnt + 16'd1;
    end
  end
`else
  assign ovf_cnt = '0;
  assign unf_cnt = '0;
`endif

endmodule

// File: tb/tb_window_ctrl.sv
// tb/tb_window_ctrl.sv - Directed and randomized checks of window_ctrl against an architectural model
module tb_window_ctrl;

  localparam int NW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic [2:0]    op_code;
  logic [31:0]   op_data;
  logic          op_ready;
  logic          done_valid;
  logic          done_trap;
  logic [7:0]    done_tt;
  logic [4:0]    cwp_out;
  logic [NW-1:0] wim_out;
  logic          et_out;
  logic          s_out;
  logic          error_mode;
  logic [15:0]   ovf_cnt;
  logic [15:0]   unf_cnt;

  int checks = 0;
  int errors = 0;

  // Architectural model state
  int          m_cwp;
  logic [NW-1:0] m_wim;
  logic        m_et, m_s, m_ps, m_err;
  logic [15:0] m_ovf, m_unf;
  logic        e_trap;
  logic [7:0]  e_tt;

  // Observations of the last op
  logic        got_valid, got_trap;
  logic [7:0]  got_tt;
  int          got_lat;

  window_ctrl #(.NWINDOWS(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .op_data    (op_data),
    .op_ready   (op_ready),
    .done_valid (done_valid),
    .done_trap  (done_trap),
    .done_tt    (done_tt),
    .cwp_out    (cwp_out),
    .wim_out    (wim_out),
    .et_out     (et_out),
    .s_out      (s_out),
    .error_mode (error_mode),
    .ovf_cnt    (ovf_cnt),
    .unf_cnt    (unf_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic wim_bit(input logic [NW-1:0] w, input int idx);
    return |(w & (NW'(1) << idx));
  endfunction

  task automatic model_reset();
    m_cwp = 0; m_wim = '0; m_et = 1'b0; m_s = 1'b1; m_ps = 1'b0; m_err = 1'b0;
    m_ovf = '0; m_unf = '0;
  endtask

  task automatic model_apply(input logic [2:0] code, input logic [31:0] data);
    int d, i;
    d = (m_cwp + NW - 1) % NW;
    i = (m_cwp + 1) % NW;
    e_trap = 1'b0;
    e_tt   = 8'h00;
    case (code)
      3'd1: if (wim_bit(m_wim, d)) begin e_trap = 1'b1; e_tt = 8'h05; end else m_cwp = d;
      3'd2: if (wim_bit(m_wim, i)) begin e_trap = 1'b1; e_tt = 8'h06; end else m_cwp = i;
      3'd3: begin
        e_tt = data[7:0];
        if (m_et) begin m_cwp = d; m_ps = m_s; m_s = 1'b1; m_et = 1'b0; end
        else begin m_err = 1'b1; e_trap = 1'b1; end
      end
      3'd4: begin
        if (m_et) begin e_trap = 1'b1; e_tt = 8'h02; end
        else if (!m_s) begin e_trap = 1'b1; e_tt = 8'h03; end
        else if (wim_bit(m_wim, i)) begin e_trap = 1'b1; e_tt = 8'h06; end
        else begin m_cwp = i; m_s = m_ps; m_et = 1'b1; end
      end
      3'd5: begin
        if (!m_s) begin e_trap = 1'b1; e_tt = 8'h03; end
        else if (int'(data[4:0]) >= NW) begin e_trap = 1'b1; e_tt = 8'h02; end
        else m_cwp = int'(data[4:0]);
      end
      3'd6: if (!m_s) begin e_trap = 1'b1; e_tt = 8'h03; end else m_wim = data[NW-1:0];
      default: ;
    endcase
`ifdef WIN_STATS_EN
    if (e_trap && e_tt == 8'h05 && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
    if (e_trap && e_tt == 8'h06 && m_unf != 16'hFFFF) m_unf = m_unf + 16'd1;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    op_valid = 1'b0; op_code = '0; op_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Issues one op and waits for its done pulse; returns observations in got_*.
  task automatic do_op(input logic [2:0] code, input logic [31:0] data);
    int n;
    n = 0;
    got_valid = 1'b0; got_trap = 1'b0; got_tt = '0; got_lat = 0;
    while (!op_ready && n < 20) begin @(negedge clk); n++; end
    if (!op_ready) return;
    op_valid = 1'b1; op_code = code; op_data = data;
    @(negedge clk);
    op_valid = 1'b0;
    got_lat = 1;
    while (!done_valid && got_lat < 10) begin @(negedge clk); got_lat++; end
    got_valid = done_valid; got_trap = done_trap; got_tt = done_tt;
  endtask

  task automatic test_reset();
    int pulses;
    do_reset();
    checks++;
    if ({cwp_out, wim_out, s_out, et_out, op_ready, error_mode, done_valid, done_trap, done_tt, ovf_cnt, unf_cnt}
        !== {5'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_values got cwp=%0d wim=%b s=%b et=%b rdy=%b err=%b dv=%b ovf=%0d unf=%0d exp cwp=0 wim=000 s=1 et=0 rdy=1 err=0 dv=0 ovf=0 unf=0",
               cwp_out, wim_out, s_out, et_out, op_ready, error_mode, done_valid, ovf_cnt, unf_cnt);
    end
    pulses = 0;
    repeat (5) begin @(negedge clk); if (done_valid) pulses++; end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_idle_no_done got pulses=%0d exp 0", pulses);
    end
  endtask

  task automatic test_save_wrap();
    logic [2:0]  codes[4] = '{3'd6, 3'd1, 3'd6, 3'd1};
    logic [31:0] datas[4] = '{32'h4, 32'h0, 32'h0, 32'h0};
    for (int k = 0; k < 4; k++) begin
      do_op(codes[k], datas[k]);
      model_apply(codes[k], datas[k]);
      checks++;
      if ({got_valid, got_trap, got_tt, cwp_out, wim_out, et_out, s_out, error_mode, ovf_cnt, unf_cnt} !==
          {1'b1, e_trap, e_tt, 5'(m_cwp), m_wim, m_et, m_s, m_err, m_ovf, m_unf} || got_lat != 2) begin
        errors++;
        $display("FAIL save_wrap[%0d] got v=%b trap=%b tt=%h cwp=%0d wim=%b et=%b s=%b lat=%0d exp v=1 trap=%b tt=%h cwp=%0d wim=%b et=%b s=%b lat=2",
                 k, got_valid, got_trap, got_tt, cwp_out, wim_out, et_out, s_out, got_lat,
                 e_trap, e_tt, m_cwp, m_wim, m_et, m_s);
      end
    end
    checks++;
    if (cwp_out !== 5'd2) begin
      errors++;
      $display("FAIL save_wraps_to_top got cwp=%0d exp 2", cwp_out);
    end
  endtask

  task automatic test_restore();
    logic [2:0]  codes[4] = '{3'd2, 3'd1, 3'd6, 3'd2};
    logic [31:0] datas[4] = '{32'h0, 32'h0, 32'h1, 32'h0};
    for (int k = 0; k < 4; k++) begin
      do_op(codes[k], datas[k]);
      model_apply(codes[k], datas[k]);
      checks++;
      if ({got_valid, got_trap, got_tt, cwp_out, wim_out, et_out, s_out, error_mode, ovf_cnt, unf_cnt} !==
          {1'b1, e_trap, e_tt, 5'(m_cwp), m_wim, m_et, m_s, m_err, m_ovf, m_unf} || got_lat != 2) begin
        errors++;
        $display("FAIL restore[%0d] got v=%b trap=%b tt=%h cwp=%0d wim=%b lat=%0d exp v=1 trap=%b tt=%h cwp=%0d wim=%b lat=2",
                 k, got_valid, got_trap, got_tt, cwp_out, wim_out, got_lat, e_trap, e_tt, m_cwp, m_wim);
      end
    end
    checks++;
    if ({got_trap, got_tt, cwp_out} !== {1'b1, 8'h06, 5'd2}) begin
      errors++;
      $display("FAIL restore_underflow got trap=%b tt=%h cwp=%0d exp trap=1 tt=06 cwp=2", got_trap, got_tt, cwp_out);
    end
  endtask

  // WRWIM 0, WRCWP 2, RETT (->ET=1,S=0,CWP=0), TRAP 0x80, RETT, then privilege/boundary traps.
  task automatic test_trap_rett_boundary();
    logic [2:0]  codes[11] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd3, 3'd5, 3'd4, 3'd4, 3'd6, 3'd5};
    logic [31:0] datas[11] = '{32'h0, 32'h2, 32'h0, 32'h80, 32'h0, 32'h11, 32'h3, 32'h0, 32'h0, 32'h7, 32'h1};
    for (int k = 0; k < 11; k++) begin
      do_op(codes[k], datas[k]);
      model_apply(codes[k], datas[k]);
      checks++;
      if ({got_valid, got_trap, got_tt, cwp_out, wim_out, et_out, s_out, error_mode, ovf_cnt, unf_cnt} !==
          {1'b1, e_trap, e_tt, 5'(m_cwp), m_wim, m_et, m_s, m_err, m_ovf, m_unf} || got_lat != 2) begin
        errors++;
        $display("FAIL trap_rett[%0d] op=%0d got v=%b trap=%b tt=%h cwp=%0d et=%b s=%b lat=%0d exp v=1 trap=%b tt=%h cwp=%0d et=%b s=%b lat=2",
                 k, codes[k], got_valid, got_trap, got_tt, cwp_out, et_out, s_out, got_lat,
                 e_trap, e_tt, m_cwp, m_et, m_s);
      end
      if (k == 3) begin
        checks++;
        if ({got_trap, got_tt, cwp_out, et_out, s_out} !== {1'b0, 8'h80, 5'd2, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL trap_enter_0x80 got trap=%b tt=%h cwp=%0d et=%b s=%b exp trap=0 tt=80 cwp=2 et=0 s=1",
                   got_trap, got_tt, cwp_out, et_out, s_out);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  code;
    logic [31:0] data;
    do_reset();
    for (int k = 0; k < 150; k++) begin
      code = 3'($urandom_range(0, 7));
      if (code == 3'd3 && !m_et) code = 3'd4;
      data = $urandom;
      if (code == 3'd5) data = 32'($urandom_range(0, 4));
      do_op(code, data);
      model_apply(code, data);
      checks++;
      if ({got_valid, got_trap, got_tt, cwp_out, wim_out, et_out, s_out, error_mode, ovf_cnt, unf_cnt} !==
          {1'b1, e_trap, e_tt, 5'(m_cwp), m_wim, m_et, m_s, m_err, m_ovf, m_unf} || got_lat != 2) begin
        errors++;
        $display("FAIL random[%0d] op=%0d data=%h got v=%b trap=%b tt=%h cwp=%0d wim=%b et=%b s=%b ovf=%0d unf=%0d lat=%0d exp trap=%b tt=%h cwp=%0d wim=%b et=%b s=%b ovf=%0d unf=%0d",
                 k, code, data, got_valid, got_trap, got_tt, cwp_out, wim_out, et_out, s_out, ovf_cnt, unf_cnt, got_lat,
                 e_trap, e_tt, m_cwp, m_wim, m_et, m_s, m_ovf, m_unf);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    do_reset();
    op_valid = 1'b1; op_code = 3'd1; op_data = '0;
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b0;
    pulses = 0;
    repeat (3) begin @(negedge clk); if (done_valid) pulses++; end
    rst = 1'b1;
    model_reset();
    repeat (3) begin @(negedge clk); if (done_valid) pulses++; end
    checks++;
    if (pulses != 0 || cwp_out !== 5'd0 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_eval got pulses=%0d cwp=%0d rdy=%b exp pulses=0 cwp=0 rdy=1", pulses, cwp_out, op_ready);
    end
  endtask

  task automatic test_stats();
    logic [2:0]  codes[6] = '{3'd6, 3'd1, 3'd1, 3'd1, 3'd6, 3'd2};
    logic [31:0] datas[6] = '{32'h4, 32'h0, 32'h0, 32'h0, 32'h2, 32'h0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      do_op(codes[k], datas[k]);
      model_apply(codes[k], datas[k]);
    end
    checks++;
`ifdef WIN_STATS_EN
    if (ovf_cnt !== 16'd3 || unf_cnt !== 16'd1 || ovf_cnt !== m_ovf) begin
`else
    if (ovf_cnt !== 16'd0 || unf_cnt !== 16'd0 || ovf_cnt !== m_ovf) begin
`endif
      errors++;
      $display("FAIL window_counters got ovf=%0d unf=%0d exp ovf=%0d unf=%0d", ovf_cnt, unf_cnt, m_ovf, m_unf);
    end
  endtask

  task automatic test_error_mode();
    int bad;
    do_reset();
    do_op(3'd3, 32'h5A);
    model_apply(3'd3, 32'h5A);
    checks++;
    if ({got_valid, got_trap, got_tt, error_mode, cwp_out} !== {1'b1, 1'b1, 8'h5A, 1'b1, 5'(m_cwp)} || got_lat != 2) begin
      errors++;
      $display("FAIL error_entry got v=%b trap=%b tt=%h err=%b cwp=%0d lat=%0d exp v=1 trap=1 tt=5a err=1 cwp=%0d lat=2",
               got_valid, got_trap, got_tt, error_mode, cwp_out, got_lat, m_cwp);
    end
    bad = 0;
    op_valid = 1'b1; op_code = 3'd1;
    repeat (20) begin @(negedge clk); if (op_ready || done_valid || !error_mode) bad++; end
    op_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL error_sticky got bad_cycles=%0d exp 0", bad);
    end
    do_reset();
    checks++;
    if (op_ready !== 1'b1 || error_mode !== 1'b0) begin
      errors++;
      $display("FAIL error_cleared_by_reset got rdy=%b err=%b exp rdy=1 err=0", op_ready, error_mode);
    end
  endtask

  initial begin
    rst = 1'b0; op_valid = 1'b0; op_code = '0; op_data = '0;
    test_reset();
    test_save_wrap();
    test_restore();
    test_trap_rett_boundary();
    test_reset_mid_op();
    test_stats();
    test_random();
    test_error_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
